// File: rtl/row_stat_upd.sv
// row_stat_upd: online-softmax running row max / exp-sum over one score tile.
// Buffers a TIL x TIL tile, sums exp(s - m_new) per row, rescales old l.
module row_stat_upd #(
    parameter int D_W = 8,
    parameter int TIL = 16
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   I_S_VLD,
    output logic                   O_S_RDY,
    input  logic                   I_FIRST,
    input  logic [TIL*D_W-1:0]     I_S_COL,
    output logic                   O_ENA,
    input  logic                   I_UPD_VLD,
    output logic [TIL*2*D_W-1:0]   O_LI_OLD,
    output logic [TIL*D_W-1:0]     O_MI_OLD,
    output logic [TIL*2*D_W-1:0]   O_LI_NEW,
    output logic [TIL*D_W-1:0]     O_MI_NEW,
    output logic                   O_BUSY
);

    localparam int CW   = (TIL > 1) ? $clog2(TIL) : 1;
    localparam int LW   = 2 * D_W;
    localparam int PW   = 3 * D_W;
    localparam int FRAC = D_W - 3;
    localparam int EN   = 2 ** (D_W - 1);
    localparam real SCL = real'(2 ** FRAC);
    localparam logic [CW-1:0] LAST  = CW'(TIL - 1);
    localparam logic [LW-1:0] L_SAT = {1'b0, {(LW-1){1'b1}}};

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        SUM    = 3'd1,
        ALPHA  = 3'd2,
        OUT    = 3'd3,
        COMMIT = 3'd4
    } state_t;

    typedef logic [TIL-1:0][D_W-1:0] mvec_t;
    typedef logic [TIL-1:0][LW-1:0]  lvec_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic          first_q, first_d;
    logic [TIL-1:0][TIL-1:0][D_W-1:0] buf_q, buf_d;
    mvec_t         tmax_q, tmax_d;
    mvec_t         m_new_q, m_new_d;
    mvec_t         m_old_q, m_old_d;
    lvec_t         l_old_q, l_old_d;
    lvec_t         l_new_q, l_new_d;
    lvec_t         sum_q, sum_d;

    logic [7:0]    e_rom [EN];
    mvec_t         s_row, tmax_upd, m_sel;
    logic [TIL-1:0][7:0] e_sum, e_alpha;
    lvec_t         l_upd;
    logic          acc, last, first_eff, show_new;

    function automatic logic gt(input logic [D_W-1:0] a,
                                input logic [D_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

    // a - b at D_W+1 bits, clamped into the ROM index range
    function automatic logic [D_W-2:0] dclamp(input logic [D_W-1:0] a,
                                              input logic [D_W-1:0] b);
        logic signed [D_W:0] d;
        d = $signed({a[D_W-1], a}) - $signed({b[D_W-1], b});
        if (d[D_W])
            dclamp = '0;
        else if (d[D_W-1])
            dclamp = '1;
        else
            dclamp = d[D_W-2:0];
    endfunction

    for (genvar i = 0; i < EN; i++) begin : g_rom
        localparam real EV = $exp(-(1.0 * i) / SCL) * SCL;
        assign e_rom[i] = 8'($rtoi(EV + 0.5));
    end

    assign s_row     = I_S_COL;
    assign acc       = I_S_VLD & O_S_RDY;
    assign last      = (col_cnt_q == LAST);
    assign first_eff = (col_cnt_q == '0) ? I_FIRST : first_q;

    for (genvar r = 0; r < TIL; r++) begin : g_row
        logic [PW-1:0] prod;
        logic [PW-1:0] l_acc;
        assign tmax_upd[r] = (col_cnt_q == '0 || gt(s_row[r], tmax_q[r]))
                           ? s_row[r] : tmax_q[r];
        assign m_sel[r]    = (first_eff || gt(tmax_upd[r], m_old_q[r]))
                           ? tmax_upd[r] : m_old_q[r];
        assign e_sum[r]    = e_rom[dclamp(m_new_q[r], buf_q[col_cnt_q][r])];
        assign e_alpha[r]  = e_rom[dclamp(m_new_q[r], m_old_q[r])];
        assign prod        = PW'(l_old_q[r]) * PW'(e_alpha[r]);
        assign l_acc       = (prod >> FRAC) + PW'(sum_q[r]);
        assign l_upd[r]    = (l_acc > PW'(L_SAT)) ? L_SAT : l_acc[LW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        first_d   = first_q;
        buf_d     = buf_q;
        tmax_d    = tmax_q;
        m_new_d   = m_new_q;
        m_old_d   = m_old_q;
        l_old_d   = l_old_q;
        l_new_d   = l_new_q;
        sum_d     = sum_q;
        unique case (state_q)
            LOAD: begin
                if (acc) begin
                    buf_d[col_cnt_q] = I_S_COL;
                    tmax_d           = tmax_upd;
                    first_d          = first_eff;
                    col_cnt_d        = col_cnt_q + 1'b1;
                    if (last) begin
                        m_new_d   = m_sel;
                        col_cnt_d = '0;
                        state_d   = SUM;
                    end
                end
            end
            SUM: begin
                for (int r = 0; r < TIL; r++)
                    sum_d[r] = sum_q[r] + LW'(e_sum[r]);
                col_cnt_d = col_cnt_q + 1'b1;
                if (last) begin
                    col_cnt_d = '0;
                    state_d   = ALPHA;
                end
            end
            ALPHA: begin
                l_new_d = first_q ? sum_q : l_upd;
                state_d = OUT;
            end
            OUT: begin
                if (I_UPD_VLD)
                    state_d = COMMIT;
            end
            COMMIT: begin
                m_old_d   = m_new_q;
                l_old_d   = l_new_q;
                sum_d     = '0;
                tmax_d    = '0;
                first_d   = 1'b0;
                col_cnt_d = '0;
                state_d   = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= LOAD;
            col_cnt_q <= '0;
            first_q   <= 1'b0;
            buf_q     <= '0;
            tmax_q    <= '0;
            m_new_q   <= '0;
            m_old_q   <= '0;
            l_old_q   <= '0;
            l_new_q   <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            first_q   <= first_d;
            buf_q     <= buf_d;
            tmax_q    <= tmax_d;
            m_new_q   <= m_new_d;
            m_old_q   <= m_old_d;
            l_old_q   <= l_old_d;
            l_new_q   <= l_new_d;
            sum_q     <= sum_d;
        end
    end

    // a first tile has no history: old m mirrors new m, old l reads 0
    assign show_new = first_q & (state_q != LOAD);

    assign O_S_RDY  = (state_q == LOAD) & ~I_RST;
    assign O_ENA    = (state_q == OUT);
    assign O_BUSY   = !((state_q == LOAD) && (col_cnt_q == '0));
    assign O_MI_OLD = show_new ? m_new_q : m_old_q;
    assign O_LI_OLD = show_new ? '0 : l_old_q;
    assign O_MI_NEW = m_new_q;
    assign O_LI_NEW = l_new_q;

endmodule

// File: tb/tb_row_stat_upd.sv
// tb_row_stat_upd: table vectors plus model-driven tiles through a scoreboard.
// Expected row stats are queued at stimulus time and popped on O_ENA.
module tb_row_stat_upd;

    localparam int D_W = 8;
    localparam int TIL = 16;
    localparam int MW  = TIL * D_W;
    localparam int LWT = TIL * 2 * D_W;

    typedef logic [TIL-1:0][TIL-1:0][D_W-1:0] tile_t;

    typedef struct {
        string          name;
        logic [MW-1:0]  mn;
        logic [MW-1:0]  mo;
        logic [LWT-1:0] ln;
        logic [LWT-1:0] lo;
    } sb_t;

    typedef struct {
        string name;
        logic  fst;
        int    pat;
        int    base;
        int    mi_new;
        int    li_new;
        int    mi_old;
        int    li_old;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           s_vld;
    logic           s_rdy;
    logic           s_first;
    logic [MW-1:0]  s_col;
    logic           ena;
    logic           upd_vld;
    logic [LWT-1:0] li_old;
    logic [MW-1:0]  mi_old;
    logic [LWT-1:0] li_new;
    logic [MW-1:0]  mi_new;
    logic           busy;

    row_stat_upd #(.D_W(D_W), .TIL(TIL)) dut (
        .I_CLK     (clk),
        .I_RST     (rst),
        .I_S_VLD   (s_vld),
        .O_S_RDY   (s_rdy),
        .I_FIRST   (s_first),
        .I_S_COL   (s_col),
        .O_ENA     (ena),
        .I_UPD_VLD (upd_vld),
        .O_LI_OLD  (li_old),
        .O_MI_OLD  (mi_old),
        .O_LI_NEW  (li_new),
        .O_MI_NEW  (mi_new),
        .O_BUSY    (busy)
    );

    sb_t  sbq[$];
    vec_t vecs[4];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_st[TIL];
    int   l_st[TIL];
    int   pm_st[TIL];
    int   pl_st[TIL];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [LWT-1:0] act,
                       input logic [LWT-1:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    function automatic int e_ref(input int d);
        int dd;
        dd = (d > 127) ? 127 : d;
        return $rtoi($exp(-dd / 32.0) * 32.0 + 0.5);
    endfunction

    function automatic logic [MW-1:0] pk_m(input int v[TIL]);
        logic [MW-1:0] res;
        for (int r = 0; r < TIL; r++)
            res[r*D_W +: D_W] = 8'(v[r]);
        return res;
    endfunction

    function automatic logic [LWT-1:0] pk_l(input int v[TIL]);
        logic [LWT-1:0] res;
        for (int r = 0; r < TIL; r++)
            res[r*16 +: 16] = 16'(v[r]);
        return res;
    endfunction

    function automatic tile_t build_tile(input int pat, input int base);
        tile_t t;
        int v;
        for (int c = 0; c < TIL; c++) begin
            for (int r = 0; r < TIL; r++) begin
                case (pat)
                    1:       v = (c < 2) ? 42 : ((c < 4) ? 5 : -128);
                    2:       v = (r - 8) + base - ((c + r) % 4) * 3;
                    default: v = base;
                endcase
                t[c][r] = 8'(v);
            end
        end
        return t;
    endfunction

    task automatic push_exp(input string nm, input int mn[TIL], input int ln[TIL],
                            input int mo[TIL], input int lo[TIL]);
        sb_t e;
        e.name = nm;
        e.mn = pk_m(mn);
        e.mo = pk_m(mo);
        e.ln = pk_l(ln);
        e.lo = pk_l(lo);
        sbq.push_back(e);
        pm_st = mn;
        pl_st = ln;
    endtask

    task automatic push_const(input vec_t v);
        int mn[TIL], ln[TIL], mo[TIL], lo[TIL];
        for (int r = 0; r < TIL; r++) begin
            mn[r] = v.mi_new;
            ln[r] = v.li_new;
            mo[r] = v.mi_old;
            lo[r] = v.li_old;
        end
        push_exp(v.name, mn, ln, mo, lo);
    endtask

    task automatic model_push(input string nm, input tile_t t, input logic fst);
        int mn[TIL], ln[TIL], mo[TIL], lo[TIL];
        for (int r = 0; r < TIL; r++) begin
            int tmax, s, sum, alpha;
            tmax = -1000;
            for (int c = 0; c < TIL; c++) begin
                s = int'($signed(t[c][r]));
                if (s > tmax) tmax = s;
            end
            mn[r] = fst ? tmax : ((m_st[r] > tmax) ? m_st[r] : tmax);
            sum = 0;
            for (int c = 0; c < TIL; c++)
                sum += e_ref(mn[r] - int'($signed(t[c][r])));
            alpha = e_ref(mn[r] - m_st[r]);
            ln[r] = fst ? sum : (((l_st[r] * alpha) >>> 5) + sum);
            if (ln[r] > 32767) ln[r] = 32767;
            mo[r] = fst ? mn[r] : m_st[r];
            lo[r] = fst ? 0 : l_st[r];
        end
        push_exp(nm, mn, ln, mo, lo);
    endtask

    task automatic send_tile(input tile_t t, input logic fst);
        int n;
        for (int c = 0; c < TIL; c++) begin
            s_col   = t[c];
            s_vld   = 1'b1;
            s_first = fst;
            n = 0;
            while (!s_rdy && n < 100) begin
                cyc(1);
                n++;
            end
            if (!s_rdy) begin
                n_chk++;
                n_err++;
                $display("FAIL rdy_timeout: col %0d got rdy=0, required 1", c);
                s_vld = 1'b0;
                return;
            end
            cyc(1);
        end
        s_vld   = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic wait_out(input int n0);
        int n;
        sb_t e;
        n = n0;
        while (!ena && n < 200) begin
            cyc(1);
            n++;
        end
        if (!ena) begin
            n_chk++;
            n_err++;
            $display("FAIL ena_timeout: got no O_ENA after %0d cycles, required 17", n);
            if (sbq.size() != 0) void'(sbq.pop_front());
            return;
        end
        chk("ena_latency", LWT'(n), LWT'(17));
        if (sbq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got O_ENA, required a queued expectation");
            return;
        end
        e = sbq.pop_front();
        chk({e.name, "_mi_new"}, LWT'(mi_new), LWT'(e.mn));
        chk({e.name, "_li_new"}, li_new, e.ln);
        chk({e.name, "_mi_old"}, LWT'(mi_old), LWT'(e.mo));
        chk({e.name, "_li_old"}, li_old, e.lo);
    endtask

    task automatic commit(input string nm);
        upd_vld = 1'b1;
        cyc(1);
        upd_vld = 1'b0;
        chk({nm, "_commit_ena"}, LWT'(ena), '0);
        chk({nm, "_commit_rdy"}, LWT'(s_rdy), '0);
        cyc(1);
        chk({nm, "_load_rdy"}, LWT'({s_rdy, busy}), LWT'(2'b10));
        chk({nm, "_li_old_cm"}, li_old, pk_l(pl_st));
        chk({nm, "_mi_old_cm"}, LWT'(mi_old), LWT'(pk_m(pm_st)));
        m_st = pm_st;
        l_st = pl_st;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, LWT'({s_rdy, ena, busy}), '0);
        chk({nm, "_li_old"}, li_old, '0);
        chk({nm, "_mi_old"}, LWT'(mi_old), '0);
        chk({nm, "_li_new"}, li_new, '0);
        chk({nm, "_mi_new"}, LWT'(mi_new), '0);
    endtask

    task automatic model_clear();
        for (int r = 0; r < TIL; r++) begin
            m_st[r] = 0;
            l_st[r] = 0;
        end
    endtask

    task automatic hold_test();
        logic ok;
        logic [LWT-1:0] l0, l1;
        logic [MW-1:0] m0, m1;
        l0 = li_new;
        l1 = li_old;
        m0 = mi_new;
        m1 = mi_old;
        ok = 1'b1;
        s_vld   = 1'b1;
        s_first = 1'b1;
        for (int i = 0; i < 50; i++) begin
            s_col = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc(1);
            if (!ena || s_rdy || !busy || li_new !== l0 || li_old !== l1 ||
                mi_new !== m0 || mi_old !== m1)
                ok = 1'b0;
        end
        s_vld   = 1'b0;
        s_first = 1'b0;
        chk("hold_stable", LWT'(ok), LWT'(1'b1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tile_t t;
        int n0;

        vecs[0] = '{"first_zero", 1'b1, 0, 0,  0, 512,  0,   0};
        vecs[1] = '{"preload",    1'b1, 1, 0, 42,  96, 42,   0};
        vecs[2] = '{"tile56",     1'b0, 0, 56, 56, 575, 42,  96};
        vecs[3] = '{"tile42",     1'b0, 0, 42, 56, 911, 56, 575};

        rst = 1'b1;
        s_vld = 1'b0;
        s_first = 1'b0;
        s_col = '0;
        upd_vld = 1'b0;
        model_clear();
        cyc(3);
        chk_zero("reset");
        rst = 1'b0;
        cyc(1);
        chk("post_rst_rdy", LWT'({s_rdy, busy}), LWT'(2'b10));

        for (int i = 0; i < 4; i++) begin
            t = build_tile(vecs[i].pat, vecs[i].base);
            push_const(vecs[i]);
            send_tile(t, vecs[i].fst);
            n0 = 0;
            if (i == 2) begin
                upd_vld = 1'b1;
                cyc(1);
                upd_vld = 1'b0;
                n0 = 1;
            end
            wait_out(n0);
            if (i == 3) hold_test();
            commit(vecs[i].name);
        end

        t = build_tile(0, 0);
        model_push("sat_first", t, 1'b1);
        send_tile(t, 1'b1);
        wait_out(0);
        commit("sat_first");
        for (int k = 0; k < 65; k++) begin
            model_push("sat", t, 1'b0);
            send_tile(t, 1'b0);
            wait_out(0);
            commit("sat");
        end
        chk("sat_clamp", li_new, {TIL{16'h7FFF}});

        t = build_tile(2, 0);
        model_push("mixed_first", t, 1'b1);
        send_tile(t, 1'b1);
        wait_out(0);
        commit("mixed_first");
        t = build_tile(2, 3);
        model_push("mixed_up", t, 1'b0);
        send_tile(t, 1'b0);
        wait_out(0);
        commit("mixed_up");

        t = build_tile(0, 0);
        send_tile(t, 1'b1);
        cyc(5);
        rst = 1'b1;
        #1;
        chk_zero("rst_sum");
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_sum_rdy", LWT'({s_rdy, busy}), LWT'(2'b10));
        model_clear();

        model_push("pre_rst_out", t, 1'b1);
        send_tile(t, 1'b1);
        wait_out(0);
        rst = 1'b1;
        #1;
        chk_zero("rst_out");
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_out_rdy", LWT'({s_rdy, busy}), LWT'(2'b10));
        model_clear();

        push_const(vecs[0]);
        send_tile(build_tile(vecs[0].pat, vecs[0].base), 1'b1);
        wait_out(0);
        commit("fresh_first");

        chk("sb_drained", LWT'(sbq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
